uart_tx_fifo: RTL

//   Byte FIFO sitting directly upstream of the UART transmitter. Host/CPU side

---
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Summary  : Byte FIFO that feeds the UART transmitter, with a registered head
//            byte. The optional sticky overflow flag is built only when
//            UART_TX_FIFO_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_data_ack
);

  localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL_LVL = c_DEPTH[DEPTH_LOG2:0];

  logic [7:0]            r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [7:0]            r_tx_data;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [DEPTH_LOG2-1:0] w_rd_next;
  logic [DEPTH_LOG2-1:0] w_wr_next;
  logic [DEPTH_LOG2:0]   w_level_next;
  logic [DEPTH_LOG2:0]   w_level_after_pop;
  logic [7:0]            w_head_next;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_FULL_LVL);
  assign w_pop   = tx_data_ack && !w_empty;
  assign w_push  = wr_en && (!w_full || w_pop);

  always_comb begin
    w_rd_next         = r_rd_ptr;
    w_wr_next         = r_wr_ptr;
    w_level_next      = r_level;
    w_level_after_pop = r_level;
    w_head_next       = r_tx_data;
    if (flush) begin
      w_rd_next    = '0;
      w_wr_next    = '0;
      w_level_next = '0;
      w_head_next  = 8'h00;
    end else begin
      if (w_pop) begin
        w_rd_next         = r_rd_ptr + 1'b1;
        w_level_after_pop = r_level - 1'b1;
      end
      if (w_push) begin
        w_wr_next = r_wr_ptr + 1'b1;
      end
      w_level_next = w_level_after_pop + {{DEPTH_LOG2{1'b0}}, w_push};
      // The next head is either absent, the byte being written right now
      // (queue momentarily drained), or an entry already in the array.
      if (w_level_next == '0) begin
        w_head_next = 8'h00;
      end else if (w_push && (w_level_after_pop == '0)) begin
        w_head_next = wr_data;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_level   <= '0;
      r_tx_data <= 8'h00;
    end else begin
      r_rd_ptr  <= w_rd_next;
      r_wr_ptr  <= w_wr_next;
      r_level   <= w_level_next;
      r_tx_data <= w_head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_ovf;

  // A set in the same cycle as a clear wins; flush leaves the flag alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (wr_en && w_full && !w_pop && !flush) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = ovf_clr;
  assign ovf              = 1'b0;
`endif

  assign level         = r_level;
  assign empty         = w_empty;
  assign full          = w_full;
  assign tx_data_valid = !w_empty;
  assign tx_data       = r_tx_data;

endmodule

`default_nettype wire
